// File: rtl/word_byte_serializer.sv
// Buffers 16-bit words in a small FIFO and streams each one out as two bytes on a
// valid/ready port, tracking a running byte checksum and a completed-word count.
module word_byte_serializer #(
    parameter int DEPTH    = 4,
    parameter bit HI_FIRST = 1'b1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [15:0]      in_word,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_byte,
    output logic             out_last,
    input  logic             out_ready,
    output logic [7:0]       byte_sum,
    output logic [CNT_W-1:0] word_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, BYTE0, BYTE1} state_t;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic [15:0]   hold;
    state_t        state, state_nxt;
    logic          push, pop, hs;

    // in_ready depends only on registered level, so a same-cycle pop never opens a slot.
    assign in_ready = (level < FULL_LVL);
    assign push     = in_valid & in_ready;
    assign hs       = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_byte  = 8'h00;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    pop       = 1'b1;
                    state_nxt = BYTE0;
                end
            end
            BYTE0: begin
                out_valid = 1'b1;
                out_byte  = HI_FIRST ? hold[15:8] : hold[7:0];
                if (out_ready) state_nxt = BYTE1;
            end
            BYTE1: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_byte  = HI_FIRST ? hold[7:0] : hold[15:8];
                if (out_ready) begin
                    if (level != '0) begin
                        pop       = 1'b1;
                        state_nxt = BYTE0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            hold       <= '0;
            byte_sum   <= '0;
            word_count <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                hold   <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
            if (hs) byte_sum <= byte_sum + out_byte;
            if (hs && state == BYTE1) word_count <= word_count + CNT_W'(1);
        end
    end
endmodule
